// File: rtl/run_gen_pkg.sv
// Shared types and constants for the run_gen capture-plus-runs stimulus generator.
package run_gen_pkg;

    localparam int unsigned DATA_W  = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LEN_W   = 3;
    localparam int unsigned CAP_LEN = 2;
    localparam int unsigned GAP_LEN = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAP  = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Segment counters count down to zero, so a segment of len cycles loads len-1.
    function automatic logic [LEN_W-1:0] seg_load_val(input logic [LEN_W-1:0] len);
        return LEN_W'(len - LEN_W'(1));
    endfunction

endpackage

// File: rtl/run_gen_seg_cnt.sv
// seg_cnt: loadable 3-bit down-counter; tc is high while the count sits at zero.
module seg_cnt
    import run_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    output logic             tc
);

    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - LEN_W'(1);
        end
    end

    // tc is registered from the next count so it lines up with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            tc  <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/run_gen.sv
// run_gen: emits a threshold capture window followed by above-threshold runs.
// Build option RUN_GEN_LFSR_EN selects LFSR-based run samples instead of thres+1.
module run_gen
    import run_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] thres,
    input  logic [CNT_W-1:0]  n_runs,
    input  logic [LEN_W-1:0]  run_len,
    output logic              strtCapCmp,
    output logic [DATA_W-1:0] sig,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  runs_sent
);

    localparam int unsigned RC_W = CNT_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] thres_q;
    logic [CNT_W-1:0]  n_runs_q;
    logic [LEN_W-1:0]  run_len_q;
    logic              accept;
    logic              reject;
    logic              more_runs;
    logic              seg_tc;
    logic              seg_load;
    logic [LEN_W-1:0]  seg_val;
    logic [DATA_W-1:0] cur_thres;
    logic [DATA_W-1:0] run_val;
    logic [DATA_W-1:0] sig_nxt;
    logic              strt_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    assign accept    = (state == IDLE) && start && (thres != 4'hF) && (run_len != '0);
    assign reject    = (state == IDLE) && start && !((thres != 4'hF) && (run_len != '0));
    assign more_runs = (RC_W'(runs_sent) + RC_W'(1)) < RC_W'(n_runs_q);

    seg_cnt u_seg_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (seg_load),
        .load_val (seg_val),
        .tc       (seg_tc)
    );

`ifdef RUN_GEN_LFSR_EN
    logic [DATA_W-1:0] lfsr;

    // x^4+x^3+1 Fibonacci LFSR, stepped on every edge that lands in a RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 4'h1;
        end else if (state_nxt == RUN) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign run_val = (lfsr > thres_q) ? lfsr : DATA_W'(thres_q + DATA_W'(1));
`else
    assign run_val = DATA_W'(thres_q + DATA_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CAP;
            CAP:  if (seg_tc) state_nxt = (n_runs_q != '0) ? RUN : DONE;
            RUN:  if (seg_tc) state_nxt = more_runs ? GAP : DONE;
            GAP:  if (seg_tc) state_nxt = RUN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers track the state.
    always_comb begin
        sig_nxt   = '0;
        strt_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        seg_load  = (state_nxt != state);
        seg_val   = '0;
        cur_thres = accept ? thres : thres_q;
        unique case (state_nxt)
            CAP: begin
                sig_nxt  = cur_thres;
                strt_nxt = (state != CAP);
                busy_nxt = 1'b1;
                seg_val  = seg_load_val(LEN_W'(CAP_LEN));
            end
            RUN: begin
                sig_nxt  = run_val;
                busy_nxt = 1'b1;
                seg_val  = seg_load_val(run_len_q);
            end
            GAP: begin
                sig_nxt  = thres_q;
                busy_nxt = 1'b1;
                seg_val  = seg_load_val(LEN_W'(GAP_LEN));
            end
            DONE: begin
                sig_nxt  = thres_q;
                busy_nxt = 1'b1;
                done_nxt = 1'b1;
            end
            default: begin
                sig_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig        <= '0;
            strtCapCmp <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            sig        <= sig_nxt;
            strtCapCmp <= strt_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= reject;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thres_q   <= '0;
            n_runs_q  <= '0;
            run_len_q <= '0;
        end else if (accept) begin
            thres_q   <= thres;
            n_runs_q  <= n_runs;
            run_len_q <= run_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            runs_sent <= '0;
        end else if ((state == RUN) && seg_tc) begin
            runs_sent <= runs_sent + CNT_W'(1);
        end
    end

endmodule
